// File: rtl/loader_arb_pkg.sv
// Shared types for the loader/save-RAM SDRAM write arbiter.
// Optional save port is enabled by LOAD_ARB_SAVE_PORT_EN in the consuming modules.
package loader_arb_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDR  = 2'd1,
        S_SAV  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ldr_entry_t;

endpackage

// File: rtl/ldr_wfifo.sv
// Loader write buffer: synchronous FIFO with sticky overflow on a dropped push.
// Independent of LOAD_ARB_SAVE_PORT_EN.
module ldr_wfifo
    import loader_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  ldr_entry_t i_din,
    output ldr_entry_t o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf
);

    localparam int PW = $clog2(DEPTH);

    ldr_entry_t        r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;
    logic              r_ovf;
    logic              w_pop;
    logic              w_push;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign o_ovf   = r_ovf;

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push)
                r_ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/load_write_arbiter.sv
// Arbitrates buffered game-loader writes and save-RAM accesses onto one SDRAM port.
// Save port, S_SAV and the burst limiter exist only with LOAD_ARB_SAVE_PORT_EN defined.
module load_write_arbiter
    import loader_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_data,
    input  logic              ldr_write,
    input  logic              sav_req,
    input  logic              sav_we,
    input  logic [ADDR_W-1:0] sav_addr,
    input  logic [DATA_W-1:0] sav_din,
    output logic              sav_ack,
    output logic [DATA_W-1:0] sav_dout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              ovf,
    output logic              busy
);

    state_t            r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    ldr_entry_t        w_head;
    ldr_entry_t        w_in;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_in  = '{addr: ldr_addr, data: ldr_data};
    assign w_pop = (r_state == S_LDR) && mem_ack;

    ldr_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (ldr_write),
        .i_pop   (w_pop),
        .i_din   (w_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ovf   (ovf)
    );

    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign busy     = !w_empty || (r_state != S_IDLE);

`ifdef LOAD_ARB_SAVE_PORT_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0]     r_burst;
    logic              r_sav_ack;
    logic [DATA_W-1:0] r_sav_dout;
    logic              w_unused_full;

    assign sav_ack       = r_sav_ack;
    assign sav_dout      = r_sav_dout;
    assign w_unused_full = w_full;
`else
    logic w_unused_sav;

    assign sav_ack      = 1'b0;
    assign sav_dout     = '0;
    assign w_unused_sav = ^{sav_req, sav_we, sav_addr, sav_din, mem_dout, w_full};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
`ifdef LOAD_ARB_SAVE_PORT_EN
            r_burst    <= '0;
            r_sav_ack  <= 1'b0;
            r_sav_dout <= '0;
`endif
        end else begin
`ifdef LOAD_ARB_SAVE_PORT_EN
            r_sav_ack <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
`ifdef LOAD_ARB_SAVE_PORT_EN
                    // Save side wins once the loader has used up its burst allowance
                    if (sav_req && (w_empty || r_burst == BW'(MAX_BURST))) begin
                        r_mem_addr <= sav_addr;
                        r_mem_din  <= sav_din;
                        r_mem_we   <= sav_we;
                        r_mem_req  <= 1'b1;
                        r_burst    <= '0;
                        r_state    <= S_SAV;
                    end else
`endif
                    if (!w_empty) begin
                        r_mem_addr <= w_head.addr;
                        r_mem_din  <= w_head.data;
                        r_mem_we   <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_LDR;
`ifdef LOAD_ARB_SAVE_PORT_EN
                        if (sav_req && r_burst != BW'(MAX_BURST))
                            r_burst <= r_burst + BW'(1);
`endif
                    end
                end
                S_LDR: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
`ifdef LOAD_ARB_SAVE_PORT_EN
                S_SAV: begin
                    if (mem_ack) begin
                        r_sav_ack  <= 1'b1;
                        r_sav_dout <= mem_dout;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
`ifdef LOAD_ARB_SAVE_PORT_EN
            if (!sav_req)
                r_burst <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_load_write_arbiter.sv
// Self-checking bench for load_write_arbiter: directed cases plus randomized loader
// traffic scored against a queue model; save-port cases run with LOAD_ARB_SAVE_PORT_EN.
module tb_load_write_arbiter;
    import loader_arb_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [DATA_W-1:0] ldr_data = '0;
    logic              ldr_write = 1'b0;
    logic              sav_req = 1'b0;
    logic              sav_we = 1'b0;
    logic [ADDR_W-1:0] sav_addr = '0;
    logic [DATA_W-1:0] sav_din = '0;
    logic              sav_ack;
    logic [DATA_W-1:0] sav_dout;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_dout = '0;
    logic              ovf;
    logic              busy;

    load_write_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_write(ldr_write),
        .sav_req(sav_req), .sav_we(sav_we), .sav_addr(sav_addr), .sav_din(sav_din),
        .sav_ack(sav_ack), .sav_dout(sav_dout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_ack(mem_ack), .mem_dout(mem_dout),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Reference: FIFO contents as a queue, plus "a transaction is outstanding"
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    logic m_req = 1'b0;
    logic m_ovf = 1'b0;
    logic sav_bg = 1'b0;

    task automatic model_clear();
        q.delete();
        m_req = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One clock: drive inputs, advance model, then compare after the edge
    task automatic cyc(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic ack);
        logic pop, grant;
        ldr_write = w;
        ldr_addr  = a;
        ldr_data  = d;
        mem_ack   = ack;
        mem_dout  = 8'($urandom);
        sav_req   = sav_bg;
        sav_we    = 1'($urandom);
        sav_addr  = 22'($urandom);
        sav_din   = 8'($urandom);
        pop   = m_req && ack;
        grant = !m_req && (q.size() > 0);
        if (pop)
            void'(q.pop_front());
        if (w) begin
            if (q.size() < DEPTH) q.push_back(ent_t'({a, d}));
            else                  m_ovf = 1'b1;
        end
        m_req = m_req ? !ack : grant;
        @(posedge clk); #1;
        chk("mem_req", mem_req, m_req);
        chk("busy", busy, (q.size() > 0) || m_req);
        chk("ovf", ovf, m_ovf);
        chk("sav_ack", sav_ack, 0);
`ifndef LOAD_ARB_SAVE_PORT_EN
        chk("sav_dout", sav_dout, 0);
`endif
        if (m_req) begin
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_din", mem_din, q[0].d);
            chk("mem_we", mem_we, 1);
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 300 && (q.size() > 0 || m_req); k++)
            cyc(1'b0, 22'($urandom), 8'($urandom), m_req && ($urandom_range(0, 2) == 0));
        chk({tag, "_drained_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ldr_write = 1'b1;
        ldr_addr  = 22'h3FFFFF;
        mem_ack   = 1'b0;
        sav_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        ldr_write = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LOAD_ARB_SAVE_PORT_EN
        sav_bg = 1'b0;
`else
        sav_bg = 1'b1;
`endif
        // Reset values, with ldr_write held high during reset
        do_reset();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_sav_ack", sav_ack, 0);
        chk("rst_sav_dout", sav_dout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        cyc(1'b0, '0, '0, 1'b0);

        // Single write: request in cycle 2, ack in cycle 5, idle in cycle 6
        cyc(1'b1, 22'h000010, 8'hA5, 1'b0);
        chk("t1_req_c1", mem_req, 0);
        cyc(1'b0, '0, '0, 1'b0);
        chk("t1_req_c2", mem_req, 1);
        chk("t1_addr", mem_addr, 22'h000010);
        chk("t1_din", mem_din, 8'hA5);
        chk("t1_we", mem_we, 1);
        repeat (3) cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);
        chk("t1_req_c6", mem_req, 0);
        chk("t1_busy_c6", busy, 0);

        // Overflow: ten back-to-back writes with no acks
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 22'(32'h100 + i), 8'(32'h50 + i), 1'b0);
            if (i == 7) chk("ovf_after_8", ovf, 0);
            if (i == 8) chk("ovf_after_9", ovf, 1);
        end
        drain("ovf");
        chk("ovf_sticky", ovf, 1);
        do_reset();
        chk("ovf_cleared", ovf, 0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 22'(32'h200 + i), 8'(i), 1'b0);
        chk("fullpop_req", mem_req, 1);
        chk("fullpop_pre_cnt", dut.u_fifo.r_count, DEPTH);
        cyc(1'b1, 22'h2FF, 8'hEE, 1'b1);
        chk("fullpop_cnt", dut.u_fifo.r_count, DEPTH);
        chk("fullpop_ovf", ovf, 0);
        drain("fullpop");

        // Randomized traffic, alternating light and heavy write load
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 120; k++)
                cyc($urandom_range(0, (ph % 2 == 0) ? 3 : 1) == 0,
                    22'($urandom), 8'($urandom),
                    m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
        end
        drain("rand");

`ifdef LOAD_ARB_SAVE_PORT_EN
        begin
            int   n_ldr;
            logic got_sav;
            logic prev_req;
            // Fairness: save read waits for exactly MAX_BURST loader grants
            do_reset();
            for (int i = 0; i < DEPTH; i++)
                cyc(1'b1, 22'(32'h300 + i), 8'(i), 1'b0);
            ldr_write = 1'b0;
            sav_req   = 1'b1;
            sav_we    = 1'b0;
            sav_addr  = 22'h380000;
            sav_din   = 8'h00;
            n_ldr     = 0;
            got_sav   = 1'b0;
            prev_req  = 1'b1;
            for (int k = 0; k < 100 && !got_sav; k++) begin
                mem_ack  = mem_req;
                mem_dout = 8'h3C;
                @(posedge clk); #1;
                if (mem_req && !prev_req) begin
                    if (mem_we) n_ldr++;
                    else        got_sav = 1'b1;
                end
                prev_req = mem_req;
            end
            chk("fair_got_sav", got_sav, 1);
            chk("fair_ldr_grants", n_ldr, 4);
            chk("fair_sav_addr", mem_addr, 22'h380000);
            chk("fair_sav_we", mem_we, 0);
            mem_ack  = 1'b1;
            mem_dout = 8'h3C;
            @(posedge clk); #1;
            chk("fair_sav_ack", sav_ack, 1);
            chk("fair_sav_dout", sav_dout, 8'h3C);
            chk("fair_req_drop", mem_req, 0);
            mem_ack = 1'b0;
            sav_req = 1'b0;
            @(posedge clk); #1;
            chk("fair_ack_pulse", sav_ack, 0);

            // Reset while a save write is outstanding
            do_reset();
            sav_req  = 1'b1;
            sav_we   = 1'b1;
            sav_addr = 22'h001234;
            sav_din  = 8'h77;
            for (int k = 0; k < 10 && !mem_req; k++) begin
                @(posedge clk); #1;
            end
            chk("rsav_req_up", mem_req, 1);
            chk("rsav_addr", mem_addr, 22'h001234);
            chk("rsav_we", mem_we, 1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset   = 1'b0;
            sav_req = 1'b0;
            chk("rsav_req_drop", mem_req, 0);
            chk("rsav_sav_ack", sav_ack, 0);
            chk("rsav_busy", busy, 0);
            chk("rsav_ovf", ovf, 0);
            chk("rsav_cnt", dut.u_fifo.r_count, 0);
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            chk("rsav_no_ack", sav_ack, 0);
            chk("rsav_still_idle", mem_req, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/load_write_arbiter.md
LOAD_WRITE_ARBITER -- requirements
Module: load_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, loader write-buffer entries; power of 2, minimum 2.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive loader grants while sav_req is pending.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports ldr_addr  in  22, ldr_data  in  8 and ldr_write  in  1: game-loader write, with a one-cycle strobe and no backpressure.
REQ-006 SHALL have ports sav_req  in  1, sav_we  in  1, sav_addr  in  22 and sav_din  in  8: save-RAM requester; sav_req is a level signal, with fields held until sav_ack.
REQ-007 SHALL have ports sav_ack  out  1 (one-cycle completion pulse) and sav_dout  out  8 (read data, valid with sav_ack).
REQ-008 SHALL have ports mem_req  out  1, mem_we  out  1, mem_addr  out  22 and mem_din  out  8: the SDRAM-side request, held stable until mem_ack.
REQ-009 SHALL have ports mem_ack  in  1 (one-cycle completion pulse) and mem_dout  in  8 (read data, valid with mem_ack).
REQ-010 SHALL have port ovf  out  1: sticky loader-FIFO overflow flag.
REQ-011 SHALL have port busy  out  1: high when the FIFO is non-empty or the FSM is not in S_IDLE.

Function
REQ-012 SHALL push {ldr_addr, ldr_data} into the FIFO on every cycle where ldr_write=1.
REQ-013 SHALL accept a push and a pop in the same cycle; count SHALL remain unchanged.
REQ-014 SHALL drop a push when the FIFO is full and no pop occurs that cycle, and SHALL set ovf=1 until reset.
REQ-015 SHALL accept a push into a full FIFO when a pop occurs in the same cycle.
REQ-016 SHALL implement FSM states S_IDLE, S_LDR and S_SAV.
REQ-017 S_IDLE grant rule: grant sav if sav_req=1 and (FIFO empty or burst_cnt==MAX_BURST); otherwise grant ldr if the FIFO is non-empty; otherwise remain in S_IDLE.
REQ-018 SHALL, on a grant, register mem_addr, mem_din and mem_we from the granted source and assert mem_req in the next cycle.
REQ-019 In S_LDR or S_SAV, mem_req and all mem_* fields SHALL stay constant until the cycle in which mem_ack=1.
REQ-020 On mem_ack in S_LDR: SHALL pop the FIFO, drop mem_req the next cycle, and return to S_IDLE.
REQ-021 On mem_ack in S_SAV: SHALL pulse sav_ack for one cycle with sav_dout=mem_dout captured from the ack cycle, drop mem_req, and return to S_IDLE.
REQ-022 burst_cnt SHALL increment on each ldr grant while sav_req=1, saturate at MAX_BURST, and clear on a sav grant or whenever sav_req=0.
REQ-023 Minimum latency from ldr_write (cycle 0) with the FIFO empty and the FSM in S_IDLE: the FIFO is written at the end of cycle 0, the grant occurs in cycle 1, and mem_req=1 in cycle 2.
REQ-024 SHALL leave one S_IDLE cycle between consecutive transactions.
REQ-025 SHALL issue loader writes in push order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 SHALL ignore mem_ack in S_IDLE.

Reset
REQ-027 On reset, SHALL set the FSM to S_IDLE, empty the FIFO, and clear burst_cnt.
REQ-028 On reset, SHALL set mem_req=0, mem_we=0, mem_addr=0, mem_din=0, sav_ack=0, sav_dout=0, ovf=0 and busy=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction and deassert mem_req in the cycle after reset is sampled; the SDRAM controller SHALL tolerate request withdrawal.
REQ-030 ldr_write asserted during reset SHALL be ignored.

Configuration
REQ-031 SHALL support macro LOAD_ARB_SAVE_PORT_EN.
REQ-032 With LOAD_ARB_SAVE_PORT_EN defined: the save port, S_SAV and burst_cnt SHALL operate as specified above.
REQ-033 Without LOAD_ARB_SAVE_PORT_EN: sav_* inputs SHALL be ignored, sav_ack and sav_dout SHALL be tied to 0, S_SAV and burst_cnt SHALL be omitted, and port list and loader behaviour SHALL be unchanged.

Structure
REQ-034 Package loader_arb_pkg SHALL hold the state enum (S_IDLE, S_LDR, S_SAV), the 22-bit address width constant and the 8-bit data width constant.
REQ-035 Sub-module ldr_wfifo SHALL implement the synchronous FIFO with push, pop, full, empty, head data and overflow detect; the FSM and arbitration SHALL remain in load_write_arbiter.

Verification
REQ-036 Single write: ldr_write with addr 0x000010 and data 0xA5 at cycle 0 -> mem_req=1 in cycle 2 with mem_addr=0x000010, mem_din=0xA5, mem_we=1; mem_ack in cycle 5 -> mem_req=0 in cycle 6 and busy=0 in cycle 6.
REQ-037 Overflow: 10 back-to-back ldr_write with mem_ack held low, FIFO_DEPTH=8 -> 8 entries accepted, ovf=1 from the 9th push onward; on acks, the 8 writes issue in original order.
REQ-038 Fairness: FIFO kept non-empty, sav_req=1 read of addr 0x380000 -> sav granted after exactly 4 loader grants; sav_ack pulses with sav_dout=mem_dout (0x3C).
REQ-039 Full with simultaneous pop: FIFO full, ldr_write in the same cycle as mem_ack in S_LDR -> push accepted, count stays 8, ovf stays 0.
REQ-040 Reset mid-operation: reset asserted while mem_req=1 in S_SAV -> mem_req=0 in the following cycle, no sav_ack, FIFO empty, ovf=0.
REQ-041 Macro off: LOAD_ARB_SAVE_PORT_EN undefined, sav_req=1 constantly -> no sav grant ever, sav_ack=0, loader traffic identical to REQ-036.
